// File: rtl/pipe_ctrl_gen.sv
// Pipeline hazard controller: backward stall propagation, bubble/flush generation,
// deferred flushes and a precise-exception sequencer. Optional stall watchdog: PIPE_CTRL_STALL_WDT_EN.
module pipe_ctrl_gen #(
    parameter int N_STG = 5,
    parameter int TMO_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N_STG-1:0] stall_req,
    input  logic [N_STG-1:0] flush_req,
    input  logic             exc_req,
    output logic [N_STG-1:0] stall,
    output logic [N_STG-1:0] flush,
    output logic             redirect_valid,
    output logic             exc_busy,
    output logic [N_STG-1:0] pend_flush,
    output logic             stall_tmo
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } exc_state_t;

    exc_state_t       state_reg;
    logic             redirect_reg;
    logic             busy_reg;
    logic [N_STG-1:0] pend_reg;
    logic [N_STG-1:0] pend_next;

    logic [N_STG-1:0] stall_base;
    logic [N_STG-1:0] stall_int;
    logic [N_STG-1:0] kill_src;
    logic [N_STG-1:0] kill_above;
    logic [N_STG-1:0] bubble;
    logic [N_STG-1:0] exc_kill;
    logic             any_stall_req;
    logic             in_drain;
    logic             in_flush;

    assign any_stall_req = |stall_req;
    assign in_drain      = (state_reg == ST_DRAIN);
    assign in_flush      = (state_reg == ST_FLUSH);

    genvar gi;
    generate
        for (gi = 0; gi < N_STG; gi++) begin : g_stage
            // A stage stalls if it or anything older than it stalls.
            assign stall_base[gi] = (|stall_req[N_STG-1:gi]) | in_drain;

            // Stage gi kills the younger stages once it is free to move;
            // bit 0 has no younger stages and is shifted out below.
            assign kill_src[gi]   = ~stall_int[gi] & (flush_req[gi] | pend_reg[gi]);
            assign kill_above[gi] = |(kill_src >> (gi + 1));

            if (gi == 0) begin : g_first
                assign bubble[gi] = 1'b0;
            end else begin : g_rest
                assign bubble[gi] = stall_int[gi-1] & ~stall_int[gi];
            end

            if (gi == N_STG - 1) begin : g_wb
                assign exc_kill[gi]  = 1'b0;
                assign pend_next[gi] = ~in_flush & stall_int[gi] & (flush_req[gi] | pend_reg[gi]);
            end else if (gi == 0) begin : g_fetch
                assign exc_kill[gi]  = in_flush;
                assign pend_next[gi] = 1'b0;
            end else begin : g_mid
                assign exc_kill[gi]  = in_flush;
                assign pend_next[gi] = ~in_flush & stall_int[gi] & (flush_req[gi] | pend_reg[gi]);
            end
        end
    endgenerate

    assign stall_int = in_flush ? '0 : stall_base;

    // The whole pipeline is frozen and emits no bubbles while held in reset.
    assign stall          = resetn ? stall_int : '1;
    assign flush          = resetn ? (kill_above | bubble | exc_kill) : '0;
    assign redirect_valid = redirect_reg;
    assign exc_busy       = busy_reg;
    assign pend_flush     = pend_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_reg <= '0;
        end else begin
            pend_reg <= pend_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= ST_IDLE;
            redirect_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (exc_req) begin
                        busy_reg <= 1'b1;
                        if (any_stall_req) begin
                            state_reg    <= ST_DRAIN;
                            redirect_reg <= 1'b0;
                        end else begin
                            state_reg    <= ST_FLUSH;
                            redirect_reg <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!any_stall_req) begin
                        state_reg    <= ST_FLUSH;
                        redirect_reg <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    state_reg    <= ST_IDLE;
                    redirect_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    redirect_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_STALL_WDT_EN
    localparam logic [TMO_W-1:0] WDT_MAX = '1;

    logic [TMO_W-1:0] wdt_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wdt_reg <= '0;
        end else if (!stall_int[0]) begin
            wdt_reg <= '0;
        end else if (wdt_reg != WDT_MAX) begin
            wdt_reg <= wdt_reg + 1'b1;
        end
    end

    assign stall_tmo = (wdt_reg == WDT_MAX);
`else
    // Watchdog not built: constant low output of the counter's width reduced.
    assign stall_tmo = &{TMO_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Self-checking bench for pipe_ctrl_gen: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_pipe_ctrl_gen;

    localparam int N     = 5;
    localparam int TMO_W = 4;
    localparam int CMAX  = (1 << TMO_W) - 1;

    localparam int PH_IDLE  = 0;
    localparam int PH_DRAIN = 1;
    localparam int PH_FLUSH = 2;

`ifdef PIPE_CTRL_STALL_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [N-1:0] stall_req = '0;
    logic [N-1:0] flush_req = '0;
    logic         exc_req = 1'b0;
    logic [N-1:0] stall;
    logic [N-1:0] flush;
    logic         redirect_valid;
    logic         exc_busy;
    logic [N-1:0] pend_flush;
    logic         stall_tmo;

    int n_checks = 0;
    int n_pass = 0;

    pipe_ctrl_gen #(.N_STG(N), .TMO_W(TMO_W)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .stall_req     (stall_req),
        .flush_req     (flush_req),
        .exc_req       (exc_req),
        .stall         (stall),
        .flush         (flush),
        .redirect_valid(redirect_valid),
        .exc_busy      (exc_busy),
        .pend_flush    (pend_flush),
        .stall_tmo     (stall_tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural reference model ----------------
    int           m_phase = PH_IDLE;
    logic [N-1:0] m_pend = '0;
    int           m_cnt = 0;

    task automatic model_step();
        logic [N-1:0] e_stall, e_flush, n_pend;
        bit e_red, e_busy, e_tmo, s, f;
        e_stall = '1; e_flush = '0; e_red = 0; e_busy = 0; e_tmo = 0;
        if (!resetn) begin
            m_phase = PH_IDLE; m_pend = '0; m_cnt = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                s = 0;
                for (int j = i; j < N; j++) if (stall_req[j]) s = 1;
                if (m_phase == PH_DRAIN) s = 1;
                if (m_phase == PH_FLUSH) s = 0;
                e_stall[i] = s;
            end
            for (int i = 0; i < N; i++) begin
                f = 0;
                if (m_phase == PH_FLUSH && i < N - 1) f = 1;
                if (i > 0 && e_stall[i-1] && !e_stall[i]) f = 1;
                for (int k = i + 1; k < N; k++)
                    if (!e_stall[k] && (flush_req[k] || m_pend[k])) f = 1;
                e_flush[i] = f;
            end
            e_red  = (m_phase == PH_FLUSH);
            e_busy = (m_phase != PH_IDLE);
            e_tmo  = WDT_ON && (m_cnt == CMAX);
        end
        chk("model_stall", stall, e_stall);
        chk("model_flush", flush, e_flush);
        chk("model_redirect", redirect_valid, e_red);
        chk("model_busy", exc_busy, e_busy);
        chk("model_pend", pend_flush, m_pend);
        chk("model_tmo", stall_tmo, e_tmo);
        if (resetn) begin
            n_pend = '0;
            if (m_phase != PH_FLUSH)
                for (int k = 1; k < N; k++)
                    n_pend[k] = e_stall[k] && (flush_req[k] || m_pend[k]);
            m_pend = n_pend;
            m_cnt = e_stall[0] ? ((m_cnt < CMAX) ? m_cnt + 1 : CMAX) : 0;
            case (m_phase)
                PH_IDLE:  if (exc_req) m_phase = (stall_req != 0) ? PH_DRAIN : PH_FLUSH;
                PH_DRAIN: if (stall_req == 0) m_phase = PH_FLUSH;
                default:  m_phase = PH_IDLE;
            endcase
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input string name, input logic [N-1:0] sr, input logic [N-1:0] fr, input logic ex);
        @(posedge clk);
        #1;
        stall_req = sr; flush_req = fr; exc_req = ex;
        @(negedge clk);
        #1;
        $display("txn %-10s sr=%b fr=%b exc=%b -> stall=%b flush=%b pend=%b redir=%b busy=%b tmo=%b",
                 name, sr, fr, ex, stall, flush, pend_flush, redirect_valid, exc_busy, stall_tmo);
    endtask

    initial begin
        int burst;
        logic [N-1:0] sr, fr;
        burst = 0;

        // Reset values, with requests present that must be masked.
        stall_req = 5'b00000; flush_req = 5'b10000;
        @(negedge clk); #1;
        chk("rst_stall", stall, 5'b11111);
        chk("rst_flush", flush, 5'b00000);
        chk("rst_redirect", redirect_valid, 1'b0);
        chk("rst_busy", exc_busy, 1'b0);
        chk("rst_pend", pend_flush, 5'b00000);
        chk("rst_tmo", stall_tmo, 1'b0);
        @(posedge clk); #1;
        resetn = 1'b1; flush_req = '0;

        // Backward stall with bubble.
        step("stall3", 5'b01000, 5'b00000, 1'b0);
        chk("stall3_stall", stall, 5'b01111);
        chk("stall3_flush", flush, 5'b10000);

        // Immediate flush.
        step("iflush2", 5'b00000, 5'b00100, 1'b0);
        chk("iflush_flush", flush, 5'b00011);
        chk("iflush_pend", pend_flush, 5'b00000);
        step("idle", 5'b00000, 5'b00000, 1'b0);
        chk("iflush_pend_after", pend_flush, 5'b00000);

        // Deferred flush.
        step("dflush_a", 5'b01000, 5'b00100, 1'b0);
        chk("dfl_a_flush", flush, 5'b10000);
        step("dflush_b", 5'b01000, 5'b00000, 1'b0);
        chk("dfl_b_pend", pend_flush, 5'b00100);
        step("dflush_c", 5'b01000, 5'b00000, 1'b0);
        chk("dfl_c_pend", pend_flush, 5'b00100);
        chk("dfl_c_flush", flush, 5'b10000);
        step("dflush_rel", 5'b00000, 5'b00000, 1'b0);
        chk("dfl_rel_flush", flush, 5'b00011);
        step("dflush_end", 5'b00000, 5'b00000, 1'b0);
        chk("dfl_end_pend", pend_flush, 5'b00000);
        chk("dfl_end_flush", flush, 5'b00000);

        // Exception while the writeback stage stalls.
        step("exc_req", 5'b10000, 5'b00000, 1'b1);
        chk("exc0_stall", stall, 5'b11111);
        chk("exc0_busy", exc_busy, 1'b0);
        step("drain1", 5'b10000, 5'b00000, 1'b0);
        chk("drain1_stall", stall, 5'b11111);
        chk("drain1_busy", exc_busy, 1'b1);
        chk("drain1_redir", redirect_valid, 1'b0);
        step("drain2", 5'b00000, 5'b00000, 1'b0);
        chk("drain2_stall", stall, 5'b11111);
        chk("drain2_redir", redirect_valid, 1'b0);
        step("eflush", 5'b00000, 5'b00000, 1'b0);
        chk("eflush_flush", flush, 5'b01111);
        chk("eflush_redir", redirect_valid, 1'b1);
        chk("eflush_stall", stall, 5'b00000);
        step("exc_idle", 5'b00000, 5'b00000, 1'b0);
        chk("exc_idle_busy", exc_busy, 1'b0);
        chk("exc_idle_redir", redirect_valid, 1'b0);

        // Exception with no stalls: redirect one cycle later.
        step("exc_fast", 5'b00000, 5'b00000, 1'b1);
        chk("fast0_redir", redirect_valid, 1'b0);
        step("fast1", 5'b00000, 5'b00000, 1'b0);
        chk("fast1_redir", redirect_valid, 1'b1);
        chk("fast1_flush", flush, 5'b01111);
        step("fast2", 5'b00000, 5'b00000, 1'b0);
        chk("fast2_redir", redirect_valid, 1'b0);

        // Reset during DRAIN with a pending flush.
        step("rdrain_a", 5'b01000, 5'b00100, 1'b1);
        step("rdrain_b", 5'b01000, 5'b00000, 1'b0);
        chk("rdrain_pend", pend_flush, 5'b00100);
        chk("rdrain_busy", exc_busy, 1'b1);
        @(posedge clk); #1;
        resetn = 1'b0; stall_req = '0;
        @(negedge clk); #1;
        chk("rdrain_rst_pend", pend_flush, 5'b00000);
        chk("rdrain_rst_busy", exc_busy, 1'b0);
        chk("rdrain_rst_stall", stall, 5'b11111);
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step("post_rst", 5'b00000, 5'b00000, 1'b0);
            chk("post_rst_redir", redirect_valid, 1'b0);
            chk("post_rst_flush", flush, 5'b00000);
        end

        // Stall watchdog.
        for (int c = 0; c < 15; c++) begin
            step("wdt_hold", 5'b00001, 5'b00000, 1'b0);
            chk("wdt_hold_tmo", stall_tmo, 1'b0);
        end
        step("wdt_drop", 5'b00000, 5'b00000, 1'b0);
        chk("wdt_drop_tmo", stall_tmo, WDT_ON);
        step("wdt_after", 5'b00000, 5'b00000, 1'b0);
        chk("wdt_after_tmo", stall_tmo, 1'b0);

        // Randomized traffic, checked every cycle by the model.
        $display("txn random    3000 cycles");
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            sr = '0; fr = '0;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 99) < 12) sr[b] = 1'b1;
                if ($urandom_range(0, 99) < 10) fr[b] = 1'b1;
            end
            if (burst == 0 && $urandom_range(0, 99) < 2) burst = $urandom_range(10, 24);
            if (burst > 0) begin
                sr[$urandom_range(0, N - 1)] = 1'b1;
                burst--;
            end
            stall_req = sr;
            flush_req = fr;
            exc_req = ($urandom_range(0, 99) < 6);
            resetn = ($urandom_range(0, 299) != 0);
        end
        @(posedge clk); #1;
        resetn = 1'b1; stall_req = '0; flush_req = '0; exc_req = 1'b0;
        @(negedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
